// File: rtl/four_one_mux_scheduler.sv
// Round-robin scheduler sharing one 4:1 mux among requesters A..D.
// Drives a registered select/one-hot grant with bounded time slots and gates Y when idle.
module four_one_mux_scheduler #(
    parameter int SLOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic [1:0] S,
    output logic [3:0] grant,
    output logic       busy,
    output logic       Y,
    output logic       o_state
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic       r_state;
    logic [1:0] r_last;
    logic [1:0] r_s;
    logic [3:0] r_grant;
    logic       r_busy;
    logic [7:0] r_cnt;

    logic [1:0] w_ptr;
    logic [1:0] w_idx;
    logic [1:0] w_win;
    logic       w_found;
    logic       w_slot_end;
    logic       w_y;

    // The owner's own index is the rotation pointer while a grant is held.
    assign w_ptr = (r_state == ST_GRANT) ? r_s : r_last;

    // Search last+1 .. last+4 so the previous winner is considered last.
    always_comb begin
        w_found = 1'b0;
        w_win   = w_ptr;
        w_idx   = w_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = w_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_slot_end = !req[r_s] || (r_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_s     <= 2'd0;
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_GRANT;
                        r_last  <= w_win;
                        r_s     <= w_win;
                        r_grant <= 4'b0001 << w_win;
                        r_busy  <= 1'b1;
                        r_cnt   <= 8'(SLOT_CYCLES - 1);
                    end
                end
                ST_GRANT: begin
                    if (w_slot_end) begin
                        if (w_found) begin
                            r_last  <= w_win;
                            r_s     <= w_win;
                            r_grant <= 4'b0001 << w_win;
                            r_cnt   <= 8'(SLOT_CYCLES - 1);
                        end else begin
                            // S is left at the previous owner on release.
                            r_state <= ST_IDLE;
                            r_grant <= 4'b0000;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_y = 1'b0;
        if (r_busy) begin
            case (r_s)
                2'd0:    w_y = A;
                2'd1:    w_y = B;
                2'd2:    w_y = C;
                default: w_y = D;
            endcase
        end
    end

    assign S       = r_s;
    assign grant   = r_grant;
    assign busy    = r_busy;
    assign Y       = w_y;
    assign o_state = r_state;

endmodule
